// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared loader FSM states, sync byte and baud divisor helper
package loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK} loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: 2-flop synchroniser, mid-start recheck, framing check
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK_50,
  input  logic       resetN,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);

  rx_state_t     state, state_d;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          half_tick, bit_tick;

  assign half_tick = (baud_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign bit_tick  = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) state <= RX_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_d = RX_START;
      RX_START: if (half_tick) state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_cnt == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (bit_tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Baud counter restarts on every state change so sampling stays centred on the start bit.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (state == RX_IDLE || state != state_d || bit_tick) baud_cnt <= '0;
      else                                                  baud_cnt <= baud_cnt + CW'(1);
      if (state == RX_DATA && bit_tick) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == RX_STOP && bit_tick) begin
      byte_valid = rx_sync;
      frame_err  = !rx_sync;
    end
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_ram_loader.sv
// rtl/uart_ram_loader.sv - UART framed image loader into RAM, holding the CPU in reset meanwhile
// Define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES without a received byte.
module uart_ram_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int LOAD_BASE      = 0,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic                  uart_rx,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

  loader_state_t state, state_d;
  logic          byte_valid, frame_err, timeout;
  logic [7:0]    byte_data, len_hi_q, hi_q, checksum;
  logic [15:0]   remaining, len_word;
  logic          len_bad;
  logic          start_frame, take_len, start_data, take_hi, take_lo, frame_ok, set_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK_50     (CLK_50),
    .resetN     (resetN),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign len_word = {len_hi_q, byte_data};
  assign len_bad  = (len_word == 16'd0) || (32'(len_word) > MAX_WORDS);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] gap_cnt;

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN)                          gap_cnt <= '0;
    else if (state == IDLE || byte_valid) gap_cnt <= '0;
    else                                  gap_cnt <= gap_cnt + 32'd1;
  end

  assign timeout = (state != IDLE) && (gap_cnt >= 32'(TIMEOUT_CYCLES));
`else
  // No gap timer: only a negative (illegal) TIMEOUT_CYCLES could make this true.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (state != IDLE && (frame_err || timeout)) begin
      state_d = IDLE;
    end else if (byte_valid) begin
      case (state)
        IDLE:    if (byte_data == SYNC_BYTE) state_d = LEN_HI;
        LEN_HI:  state_d = LEN_LO;
        LEN_LO:  state_d = len_bad ? IDLE : DATA_HI;
        DATA_HI: state_d = DATA_LO;
        DATA_LO: state_d = (remaining == 16'd1) ? CHECK : DATA_HI;
        CHECK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start_frame = 1'b0;
    take_len    = 1'b0;
    start_data  = 1'b0;
    take_hi     = 1'b0;
    take_lo     = 1'b0;
    frame_ok    = 1'b0;
    set_err     = 1'b0;
    if (state != IDLE && (frame_err || timeout)) begin
      set_err = 1'b1;
    end else if (byte_valid) begin
      case (state)
        IDLE:    start_frame = (byte_data == SYNC_BYTE);
        LEN_HI:  take_len = 1'b1;
        LEN_LO:  begin
          set_err    = len_bad;
          start_data = !len_bad;
        end
        DATA_HI: take_hi = 1'b1;
        DATA_LO: take_lo = 1'b1;
        CHECK:   begin
          frame_ok = (byte_data == checksum);
          set_err  = (byte_data != checksum);
        end
        default: ;
      endcase
    end
  end

  // cpu_hold is only ever cleared by a verified checksum; every error path leaves it set.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len_hi_q  <= '0;
      hi_q      <= '0;
      checksum  <= '0;
      remaining <= '0;
    end else begin
      ram_we    <= take_lo;
      load_done <= frame_ok;
      if (ram_we) ram_addr <= ram_addr + 1'b1;
      if (start_frame) begin
        cpu_hold <= 1'b1;
        load_err <= 1'b0;
      end
      if (set_err)  load_err <= 1'b1;
      if (frame_ok) cpu_hold <= 1'b0;
      if (take_len) len_hi_q <= byte_data;
      if (start_data) begin
        ram_addr  <= ADDR_WIDTH'(LOAD_BASE);
        checksum  <= '0;
        remaining <= len_word;
      end
      if (take_hi) begin
        hi_q     <= byte_data;
        checksum <= checksum ^ byte_data;
      end
      if (take_lo) begin
        ram_wdata <= DATA_WIDTH'({hi_q, byte_data});
        checksum  <= checksum ^ byte_data;
        remaining <= remaining - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// tb/tb_uart_ram_loader.sv - randomized self-checking bench for uart_ram_loader with a frame-level model
module tb_uart_ram_loader;

  localparam int CPB = 10;
  localparam int AW  = 12;

  typedef logic [7:0]  bq_t[$];
  typedef logic [27:0] wr_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic we0, we1, hold0, hold1, done0, done1, err0, err1;
  logic [11:0] addr0, addr1;
  logic [15:0] wd0, wd1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bv_cyc0 = 0, bv_cyc1 = 0;
  int ndone0 = 0, ndone1 = 0, lat_bad0 = 0, lat_bad1 = 0;
  wr_t got0[$];
  wr_t got1[$];

  bq_t fr;
  wr_t exp_q[$];
  int  exp_done;
  bit  m_hold[2];
  bit  m_err[2];

  uart_ram_loader #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_WIDTH(16), .ADDR_WIDTH(AW),
                    .LOAD_BASE(0), .TIMEOUT_CYCLES(1000)) dut0 (
    .CLK_50(clk), .resetN(resetN), .uart_rx(rx0), .ram_we(we0), .ram_addr(addr0),
    .ram_wdata(wd0), .cpu_hold(hold0), .load_done(done0), .load_err(err0));

  uart_ram_loader #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_WIDTH(16), .ADDR_WIDTH(AW),
                    .LOAD_BASE(12'hFFF), .TIMEOUT_CYCLES(1000)) dut1 (
    .CLK_50(clk), .resetN(resetN), .uart_rx(rx1), .ram_we(we1), .ram_addr(addr1),
    .ram_wdata(wd1), .cpu_hold(hold1), .load_done(done1), .load_err(err1));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut0.u_rx.byte_valid) bv_cyc0 = cyc;
    if (dut1.u_rx.byte_valid) bv_cyc1 = cyc;
    if (we0) begin
      got0.push_back({addr0, wd0});
      if (cyc != bv_cyc0 + 1) lat_bad0++;
    end
    if (we1) begin
      got1.push_back({addr1, wd1});
      if (cyc != bv_cyc1 + 1) lat_bad1++;
    end
    if (done0) ndone0++;
    if (done1) ndone1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v);
    if (w == 0) rx0 = v;
    else        rx1 = v;
  endtask

  task automatic send_byte(input int w, input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(w, bits[i]);
      repeat (CPB) @(negedge clk);
    end
    drive(w, 1'b1);
    repeat (CPB + $urandom_range(0, 15)) @(negedge clk);
  endtask

  task automatic make_frame(input int n, input int ngarb, input bit corrupt);
    logic [7:0] chk, b;
    fr.delete();
    chk = 8'h00;
    for (int g = 0; g < ngarb; g++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      fr.push_back(b);
    end
    fr.push_back(8'hA5);
    fr.push_back(8'(n >> 8));
    fr.push_back(8'(n));
    for (int k = 0; k < 2 * n; k++) begin
      b = 8'($urandom);
      fr.push_back(b);
      chk ^= b;
    end
    fr.push_back(corrupt ? ~chk : chk);
  endtask

  // Frame-level reference: find sync, validate length, list word writes, verify the XOR.
  task automatic model(input int w, input int base, input int badi);
    int s, lim, n;
    logic [7:0] chk;
    exp_q.delete();
    exp_done = 0;
    s = -1;
    for (int i = 0; i < fr.size(); i++)
      if (s < 0 && fr[i] == 8'hA5 && i != badi) s = i;
    if (s < 0) return;
    m_hold[w] = 1'b1;
    m_err[w]  = 1'b0;
    lim = (badi > s) ? badi : fr.size();
    if (s + 2 >= lim) begin m_err[w] = (badi > s); return; end
    n = {fr[s+1], fr[s+2]};
    if (n == 0 || n > (1 << AW)) begin m_err[w] = 1'b1; return; end
    chk = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (s + 4 + 2 * k >= lim) begin m_err[w] = (badi > s); return; end
      exp_q.push_back({12'((base + k) % (1 << AW)), fr[s+3+2*k], fr[s+4+2*k]});
      chk ^= fr[s+3+2*k] ^ fr[s+4+2*k];
    end
    if (s + 3 + 2 * n >= lim) begin m_err[w] = (badi > s); return; end
    if (fr[s+3+2*n] == chk) begin exp_done = 1; m_hold[w] = 1'b0; end
    else m_err[w] = 1'b1;
  endtask

  task automatic run_frame(input int w, input int base, input int badi, input string tag);
    int g0, d0, l0, nd, lb;
    logic er, hd;
    wr_t g[$];
    if (w == 0) begin g0 = got0.size(); d0 = ndone0; l0 = lat_bad0; end
    else        begin g0 = got1.size(); d0 = ndone1; l0 = lat_bad1; end
    for (int i = 0; i < fr.size(); i++) send_byte(w, fr[i], (i == badi) ? 1'b0 : 1'b1);
    repeat (20) @(posedge clk);
    #1;
    model(w, base, badi);
    g.delete();
    if (w == 0) begin
      for (int i = g0; i < got0.size(); i++) g.push_back(got0[i]);
      nd = ndone0 - d0; lb = lat_bad0 - l0; er = err0; hd = hold0;
    end else begin
      for (int i = g0; i < got1.size(); i++) g.push_back(got1[i]);
      nd = ndone1 - d0; lb = lat_bad1 - l0; er = err1; hd = hold1;
    end
    check({tag, ".nwr"}, g.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < g.size()) check({tag, ".wr"}, g[i], exp_q[i]);
    check({tag, ".done"}, nd, exp_done);
    check({tag, ".err"}, er, m_err[w]);
    check({tag, ".hold"}, hd, m_hold[w]);
    check({tag, ".lat"}, lb, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out0", {we0, addr0, wd0, hold0, done0, err0}, 32'h0);
    check("rst_out1", {we1, addr1, wd1, hold1, done1, err1}, 32'h0);
    resetN = 1'b1;
    m_hold = '{1'b0, 1'b0};
    m_err  = '{1'b0, 1'b0};
    repeat (5) @(negedge clk);

    fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame(0, 0, -1, "good");
    fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_frame(0, 0, -1, "badchk");
    make_frame(2, 0, 1'b0);
    run_frame(0, 0, -1, "reload");

    fr = {8'h00, 8'hFF, 8'h3C};
    run_frame(0, 0, -1, "garbage");
    make_frame(1, 0, 1'b0);
    run_frame(0, 0, -1, "one_word");

    fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame(0, 0, 4, "stopbit");
    make_frame(1, 0, 1'b0);
    run_frame(0, 0, -1, "after_ferr");

    fr = {8'hA5, 8'h00, 8'h00};
    run_frame(0, 0, -1, "len0");
    fr = {8'hA5, 8'h10, 8'h01};
    run_frame(0, 0, -1, "len1001");

    for (int r = 0; r < 6; r++) begin
      make_frame($urandom_range(1, 5), $urandom_range(0, 2), ($urandom_range(0, 2) == 0));
      run_frame(0, 0, -1, "rand");
    end

    make_frame(2, 0, 1'b0);
    run_frame(1, 12'hFFF, -1, "wrap");

`ifdef LOADER_TIMEOUT_EN
    fr = {8'hA5, 8'h00, 8'h01, 8'h12};
    for (int i = 0; i < fr.size(); i++) send_byte(0, fr[i], 1'b1);
    repeat (900) @(posedge clk);
    #1;
    check("tmo_early", err0, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    check("tmo_err", err0, 1'b1);
    check("tmo_hold", hold0, 1'b1);
    m_err[0]  = 1'b1;
    m_hold[0] = 1'b1;
`endif

    fr = {8'hA5, 8'h00, 8'h02, 8'h12};
    for (int i = 0; i < fr.size(); i++) send_byte(1, fr[i], 1'b1);
    check("mid_hold", hold1, 1'b1);
    @(negedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check("arst_out1", {we1, addr1, wd1, hold1, done1, err1}, 32'h0);
    check("arst_out0", {we0, addr0, wd0, hold0, done0, err0}, 32'h0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    m_hold = '{1'b0, 1'b0};
    m_err  = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    make_frame(1, 0, 1'b0);
    run_frame(1, 12'hFFF, -1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
